pe_row_sched: RTL and testbench

//  Scheduler for one row of NUM_PE pe_r_8 processing elements.

---
 rtl/pe_row_sched_if.sv | 33 +++
 rtl/pe_row_sched.sv | 126 ++++++++++++
 tb/tb_pe_row_sched.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/pe_row_sched_if.sv
// Handshake bundle between the GEMM/unary requesters, operand feeders and the
// PE row scheduler. master = requester/feeder side, slave = scheduler.
interface pe_row_sched_if #(
    parameter int LEN_BW = 8
);
    logic              gemm_req;
    logic [LEN_BW-1:0] gemm_len;
    logic              gemm_gnt;
    logic              uno_req;
    logic [1:0]        uno_op;
    logic [LEN_BW-1:0] uno_len;
    logic              uno_gnt;
    logic              hold_i;
    logic [1:0]        gemm_uno_o;
    logic              pe_en_o;
    logic [LEN_BW-1:0] issue_cnt_o;
    logic              res_vld_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;

    modport master (
        output gemm_req, gemm_len, uno_req, uno_op, uno_len, hold_i,
        input  gemm_gnt, uno_gnt, gemm_uno_o, pe_en_o, issue_cnt_o,
               res_vld_o, busy_o, done_o, err_o
    );

    modport slave (
        input  gemm_req, gemm_len, uno_req, uno_op, uno_len, hold_i,
        output gemm_gnt, uno_gnt, gemm_uno_o, pe_en_o, issue_cnt_o,
               res_vld_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/pe_row_sched.sv
// Row scheduler for a chain of NUM_PE PEs: arbitrates GEMM vs unary jobs,
// issues operands, tracks in-flight results and drains before a mode change.
module pe_row_sched #(
    parameter int NUM_PE = 8,
    parameter int LEN_BW = 8
) (
    input  logic clk,
    input  logic rst_n,
    pe_row_sched_if.slave bus
);
    localparam int LAT = NUM_PE + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic [1:0]        op;
        logic [LEN_BW-1:0] len;
    } job_t;

    state_t            st, st_nxt;
    job_t              job, job_nxt;
    logic              rr_uno_last, rr_nxt;
    logic              uno_req_q;
    logic              uno_ok;
    logic              gnt_g, gnt_u, issue;
    logic              in_flight;
    logic [LEN_BW-1:0] cnt_q, cnt_inc;
    logic [1:0]        mode_q;
    logic              gemm_gnt_q, uno_gnt_q, pe_en_q, busy_q, done_q, err_q;
    logic [LAT:1]      vld_pipe;

    // An op of 00 is not a unary job, so that request is invisible to arbitration.
    assign uno_ok    = bus.uno_req && (bus.uno_op != 2'b00);
    assign cnt_inc   = cnt_q + LEN_BW'(1);
    // Anything still able to reach res_vld_o after this cycle.
    assign in_flight = pe_en_q | (|vld_pipe[LAT-1:1]);

    always_comb begin
        st_nxt  = st;
        job_nxt = job;
        rr_nxt  = rr_uno_last;
        gnt_g   = 1'b0;
        gnt_u   = 1'b0;
        issue   = 1'b0;
        case (st)
            IDLE: begin
                if (bus.gemm_req && (!uno_ok || rr_uno_last)) begin
                    gnt_g   = 1'b1;
                    job_nxt = '{op: 2'b00, len: bus.gemm_len};
                    rr_nxt  = 1'b0;
                end else if (uno_ok) begin
                    gnt_u   = 1'b1;
                    job_nxt = '{op: bus.uno_op, len: bus.uno_len};
                    rr_nxt  = 1'b1;
                end
                if (gnt_g || gnt_u)
                    st_nxt = (job_nxt.len == '0) ? DRAIN : RUN;
            end
            RUN: begin
                if (!bus.hold_i) begin
                    issue = 1'b1;
                    if (cnt_inc == job.len)
                        st_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!in_flight)
                    st_nxt = IDLE;
            end
            default: st_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= IDLE;
            job         <= '0;
            rr_uno_last <= 1'b1;
            uno_req_q   <= 1'b0;
            cnt_q       <= '0;
            mode_q      <= 2'b00;
            gemm_gnt_q  <= 1'b0;
            uno_gnt_q   <= 1'b0;
            pe_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            vld_pipe    <= '0;
        end else begin
            st          <= st_nxt;
            job         <= job_nxt;
            rr_uno_last <= rr_nxt;
            uno_req_q   <= bus.uno_req;
            gemm_gnt_q  <= gnt_g;
            uno_gnt_q   <= gnt_u;
            pe_en_q     <= issue;
            busy_q      <= (st_nxt != IDLE);
            done_q      <= (st == DRAIN) && (st_nxt == IDLE);
            err_q       <= bus.uno_req && !uno_req_q && (bus.uno_op == 2'b00);
            vld_pipe    <= {vld_pipe[LAT-1:1], pe_en_q};
            // Mode follows the job one cycle after the grant and drops only once drained.
            mode_q      <= (st == IDLE || st_nxt == IDLE) ? 2'b00 : job.op;
            if ((st == DRAIN && st_nxt == IDLE) || gnt_g || gnt_u)
                cnt_q <= '0;
            else if (issue)
                cnt_q <= cnt_inc;
        end
    end

    assign bus.gemm_gnt    = gemm_gnt_q;
    assign bus.uno_gnt     = uno_gnt_q;
    assign bus.gemm_uno_o  = mode_q;
    assign bus.pe_en_o     = pe_en_q;
    assign bus.issue_cnt_o = cnt_q;
    assign bus.res_vld_o   = vld_pipe[LAT];
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.err_o       = err_q;

    a_gnt_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(gemm_gnt_q && uno_gnt_q));
    a_issue_busy: assert property (@(posedge clk) disable iff (!rst_n)
        pe_en_q |-> busy_q);
    a_mode_hold: assert property (@(posedge clk) disable iff (!rst_n)
        in_flight |=> $stable(mode_q));
endmodule

// File: tb/tb_pe_row_sched.sv
// Directed bench for pe_row_sched: each step is a clock window sampled 1ns
// after the rising edge; w counts windows from the cycle a request is raised.
module tb_pe_row_sched;
    localparam int NUM_PE = 8;
    localparam int LEN_BW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

    pe_row_sched_if #(.LEN_BW(LEN_BW)) bus ();

    pe_row_sched #(.NUM_PE(NUM_PE), .LEN_BW(LEN_BW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int w, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s w=%0d: observed %0h expected %0h", tag, w, obs, exp);
        end
    endtask

    function automatic logic [31:0] rng(input int w, input int lo, input int hi);
        return (w >= lo && w <= hi) ? 32'd1 : 32'd0;
    endfunction

    function automatic logic [31:0] all_outs();
        return {13'd0, bus.gemm_gnt, bus.uno_gnt, bus.gemm_uno_o, bus.pe_en_o,
                bus.issue_cnt_o, bus.res_vld_o, bus.busy_o, bus.done_o, bus.err_o};
    endfunction

    initial begin
        bus.gemm_req = 1'b0; bus.gemm_len = '0;
        bus.uno_req  = 1'b0; bus.uno_op   = 2'b00; bus.uno_len = '0;
        bus.hold_i   = 1'b0;

        // Reset state
        step(); step();
        chk("rst_outs", 0, all_outs(), 32'd0);
        rst_n = 1'b1;

        // 1: GEMM len=4, no stalls
        bus.gemm_len = 8'd4; bus.gemm_req = 1'b1;
        for (int w = 1; w <= 15; w++) begin
            step();
            chk("t1_gnt",   w, bus.gemm_gnt,   (w == 1) ? 32'd1 : 32'd0);
            chk("t1_pe_en", w, bus.pe_en_o,    rng(w, 2, 5));
            chk("t1_res",   w, bus.res_vld_o,  rng(w, 11, 14));
            chk("t1_done",  w, bus.done_o,     (w == 15) ? 32'd1 : 32'd0);
            chk("t1_mode",  w, bus.gemm_uno_o, 32'd0);
            chk("t1_busy",  w, bus.busy_o,     rng(w, 1, 14));
            chk("t1_cnt",   w, bus.issue_cnt_o,
                (w >= 2 && w <= 5) ? 32'(w - 1) : (w >= 6 && w <= 14) ? 32'd4 : 32'd0);
            if (w == 1) bus.gemm_req = 1'b0;
        end

        // 2: unary exp len=3, stall on the 2nd issue
        bus.uno_op = 2'b10; bus.uno_len = 8'd3; bus.uno_req = 1'b1;
        for (int w = 1; w <= 15; w++) begin
            step();
            chk("t2_gnt",   w, bus.uno_gnt,    (w == 1) ? 32'd1 : 32'd0);
            chk("t2_mode",  w, bus.gemm_uno_o, rng(w, 2, 14) * 32'd2);
            chk("t2_pe_en", w, bus.pe_en_o,    (w == 2 || w == 4 || w == 5) ? 32'd1 : 32'd0);
            chk("t2_res",   w, bus.res_vld_o,  (w == 11 || w == 13 || w == 14) ? 32'd1 : 32'd0);
            chk("t2_done",  w, bus.done_o,     (w == 15) ? 32'd1 : 32'd0);
            chk("t2_cnt",   w, bus.issue_cnt_o,
                (w == 2 || w == 3) ? 32'd1 : (w == 4) ? 32'd2 : rng(w, 5, 14) * 32'd3);
            if (w == 1) bus.uno_req = 1'b0;
            if (w == 2) bus.hold_i = 1'b1;
            if (w == 3) bus.hold_i = 1'b0;
        end

        // 3: simultaneous requests after reset; ties alternate
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.gemm_len = 8'd0; bus.uno_len = 8'd0; bus.uno_op = 2'b01;
        bus.gemm_req = 1'b1; bus.uno_req = 1'b1;
        for (int w = 1; w <= 12; w++) begin
            step();
            chk("t3_ggnt", w, bus.gemm_gnt, (w == 1 || w == 5 || w == 9) ? 32'd1 : 32'd0);
            chk("t3_ugnt", w, bus.uno_gnt,  (w == 3 || w == 7 || w == 11) ? 32'd1 : 32'd0);
            chk("t3_done", w, bus.done_o,   (w % 2 == 0) ? 32'd1 : 32'd0);
            chk("t3_err",  w, bus.err_o,    32'd0);
            case (w)
                1:  bus.gemm_req = 1'b0;
                3:  bus.uno_req  = 1'b0;
                4:  begin bus.gemm_req = 1'b1; bus.uno_req = 1'b1; end
                5:  bus.gemm_req = 1'b0;
                6:  bus.gemm_req = 1'b1;
                7:  bus.uno_req  = 1'b0;
                8:  bus.uno_req  = 1'b1;
                9:  bus.gemm_req = 1'b0;
                11: bus.uno_req  = 1'b0;
                default: ;
            endcase
        end

        // 4: illegal op then log len=2
        bus.uno_op = 2'b00; bus.uno_len = 8'd2; bus.uno_req = 1'b1;
        for (int w = 1; w <= 15; w++) begin
            step();
            chk("t4_err",   w, bus.err_o,      (w == 1) ? 32'd1 : 32'd0);
            chk("t4_gnt",   w, bus.uno_gnt,    (w == 3) ? 32'd1 : 32'd0);
            chk("t4_busy",  w, bus.busy_o,     rng(w, 3, 14));
            chk("t4_mode",  w, bus.gemm_uno_o, rng(w, 4, 14) * 32'd3);
            chk("t4_pe_en", w, bus.pe_en_o,    rng(w, 4, 5));
            chk("t4_res",   w, bus.res_vld_o,  rng(w, 13, 14));
            chk("t4_done",  w, bus.done_o,     (w == 15) ? 32'd1 : 32'd0);
            if (w == 2) bus.uno_op = 2'b11;
            if (w == 3) bus.uno_req = 1'b0;
        end

        // 5: GEMM len=0
        bus.gemm_len = 8'd0; bus.gemm_req = 1'b1;
        for (int w = 1; w <= NUM_PE + 3; w++) begin
            step();
            chk("t5_gnt",   w, bus.gemm_gnt,    (w == 1) ? 32'd1 : 32'd0);
            chk("t5_pe_en", w, bus.pe_en_o,     32'd0);
            chk("t5_res",   w, bus.res_vld_o,   32'd0);
            chk("t5_done",  w, bus.done_o,      (w == 2) ? 32'd1 : 32'd0);
            chk("t5_cnt",   w, bus.issue_cnt_o, 32'd0);
            if (w == 1) bus.gemm_req = 1'b0;
        end

        // 6: reset during DRAIN with 3 results still in flight
        bus.gemm_len = 8'd5; bus.gemm_req = 1'b1;
        for (int w = 1; w <= 12; w++) begin
            step();
            chk("t6_pe_en", w, bus.pe_en_o,   rng(w, 2, 6));
            chk("t6_res",   w, bus.res_vld_o, rng(w, 11, 12));
            if (w == 1) bus.gemm_req = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("t6_rst_outs", 12, all_outs(), 32'd0);
        step();
        rst_n = 1'b1;
        for (int w = 1; w <= 20; w++) begin
            step();
            chk("t6_post_res",  w, bus.res_vld_o, 32'd0);
            chk("t6_post_done", w, bus.done_o,    32'd0);
            chk("t6_post_busy", w, bus.busy_o,    32'd0);
        end
        bus.gemm_len = 8'd2; bus.gemm_req = 1'b1;
        for (int w = 1; w <= 13; w++) begin
            step();
            chk("t6_new_gnt",  w, bus.gemm_gnt,  (w == 1) ? 32'd1 : 32'd0);
            chk("t6_new_pe",   w, bus.pe_en_o,   rng(w, 2, 3));
            chk("t6_new_res",  w, bus.res_vld_o, rng(w, 11, 12));
            chk("t6_new_done", w, bus.done_o,    (w == 13) ? 32'd1 : 32'd0);
            if (w == 1) bus.gemm_req = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
